ram_tp_be_32x64_ctrl: RTL and testbench

Controller for the 32x64 two-port byte-enable line buffer. It arbitrates the single write port between two write requesters using a round-robin scheme with a req/ack handshake. It also sequences the read port as an address-wrapping burst engine that returns rows with a valid strobe. It sits between the encoder stage logic and the RAM wrapper, and drives the RAM's high-active write/read enables directly.

---
 rtl/ram_tp_be_32x64_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ram_tp_be_32x64_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tp_be_32x64_ctrl.sv
// rtl/ram_tp_be_32x64_ctrl.sv - write arbiter and wrapping read-burst sequencer for the 32x64 byte-enable line buffer
//
// Two write requesters share the RAM write port under round-robin arbitration
// with a req/ack handshake. The read port is driven by a burst engine that
// issues len consecutive row addresses (wrapping at the top of the RAM) and
// returns the rows with a valid strobe and an end-of-burst pulse.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   wr0_req_i/adr/ena/dat     requester 0 write request (held until ack)
//   wr0_ack_o                 requester 0 write issued this cycle
//   wr1_*                     same for requester 1
//   rd_start_i/base/len       burst start pulse, first row, row count (1..32)
//   rd_busy_o                 burst in progress
//   rd_val_o/rd_dat_o         read data strobe and data
//   rd_done_o                 pulse with the last valid row
//   ram_wr_ena/adr/dat_o      RAM write port (bit enables, high active)
//   ram_rd_ena/adr_o          RAM read port
//   ram_rd_dat_i              RAM read data, one cycle after ram_rd_ena_o

module ram_tp_be_32x64_ctrl #(
  parameter int ADR_WD = 5,
  parameter int DAT_WD = 64,
  parameter int LEN_WD = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr0_req_i,
  input  logic [ADR_WD-1:0] wr0_adr_i,
  input  logic [DAT_WD-1:0] wr0_ena_i,
  input  logic [DAT_WD-1:0] wr0_dat_i,
  output logic              wr0_ack_o,
  input  logic              wr1_req_i,
  input  logic [ADR_WD-1:0] wr1_adr_i,
  input  logic [DAT_WD-1:0] wr1_ena_i,
  input  logic [DAT_WD-1:0] wr1_dat_i,
  output logic              wr1_ack_o,
  input  logic              rd_start_i,
  input  logic [ADR_WD-1:0] rd_base_i,
  input  logic [LEN_WD-1:0] rd_len_i,
  output logic              rd_busy_o,
  output logic              rd_val_o,
  output logic [DAT_WD-1:0] rd_dat_o,
  output logic              rd_done_o,
  output logic [DAT_WD-1:0] ram_wr_ena_o,
  output logic [ADR_WD-1:0] ram_wr_adr_o,
  output logic [DAT_WD-1:0] ram_wr_dat_o,
  output logic              ram_rd_ena_o,
  output logic [ADR_WD-1:0] ram_rd_adr_o,
  input  logic [DAT_WD-1:0] ram_rd_dat_i
);

  localparam logic [LEN_WD-1:0] MAX_LEN = LEN_WD'(2 ** ADR_WD);

  // ---------------------------------------------------------------------------
  // Write arbiter
  // ---------------------------------------------------------------------------
  logic last_gnt;   // 1: requester 1 was granted most recently
  logic elig0, elig1;
  logic gnt0, gnt1;

  always_comb begin
    // A requester in its own ack cycle still shows req high from the old
    // transaction; masking it avoids a duplicate write.
    elig0 = wr0_req_i & ~wr0_ack_o;
    elig1 = wr1_req_i & ~wr1_ack_o;
    gnt0  = elig0 & (~elig1 | last_gnt);
    gnt1  = elig1 & (~elig0 | ~last_gnt);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_gnt     <= 1'b1;
      wr0_ack_o    <= 1'b0;
      wr1_ack_o    <= 1'b0;
      ram_wr_ena_o <= '0;
      ram_wr_adr_o <= '0;
      ram_wr_dat_o <= '0;
    end else begin
      wr0_ack_o <= gnt0;
      wr1_ack_o <= gnt1;
      if (gnt0) begin
        last_gnt     <= 1'b0;
        ram_wr_ena_o <= wr0_ena_i;
        ram_wr_adr_o <= wr0_adr_i;
        ram_wr_dat_o <= wr0_dat_i;
      end else if (gnt1) begin
        last_gnt     <= 1'b1;
        ram_wr_ena_o <= wr1_ena_i;
        ram_wr_adr_o <= wr1_adr_i;
        ram_wr_dat_o <= wr1_dat_i;
      end else begin
        // Idle: no write; address and data keep their last values.
        ram_wr_ena_o <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read burst FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

  rd_state_t         state, state_nxt;
  logic [LEN_WD-1:0] rem, rem_nxt;   // rows still to issue after the current one
  logic [ADR_WD-1:0] adr_nxt;
  logic              ena_nxt;
  logic              done_nxt;
  logic              len_ok;

  assign len_ok    = (rd_len_i != '0) && (rd_len_i <= MAX_LEN);
  assign rd_busy_o = (state != ST_IDLE);
  assign rd_dat_o  = ram_rd_dat_i;

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    adr_nxt   = ram_rd_adr_o;
    ena_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_start_i && len_ok) begin
          state_nxt = ST_RUN;
          adr_nxt   = rd_base_i;
          rem_nxt   = rd_len_i - LEN_WD'(1);
          ena_nxt   = 1'b1;
        end
      end
      ST_RUN: begin
        if (rem == '0) begin
          // Last row issued this cycle; its data returns during DRAIN.
          state_nxt = ST_DRAIN;
          done_nxt  = 1'b1;
        end else begin
          // Natural ADR_WD-bit overflow gives the 31 -> 0 wrap.
          adr_nxt = ram_rd_adr_o + ADR_WD'(1);
          rem_nxt = rem - LEN_WD'(1);
          ena_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      rem          <= '0;
      ram_rd_ena_o <= 1'b0;
      ram_rd_adr_o <= '0;
      rd_val_o     <= 1'b0;
      rd_done_o    <= 1'b0;
    end else begin
      state        <= state_nxt;
      rem          <= rem_nxt;
      ram_rd_ena_o <= ena_nxt;
      ram_rd_adr_o <= adr_nxt;
      rd_val_o     <= ram_rd_ena_o;
      rd_done_o    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ram_tp_be_32x64_ctrl.sv
// tb/tb_ram_tp_be_32x64_ctrl.sv - directed self-checking bench for ram_tp_be_32x64_ctrl
module tb_ram_tp_be_32x64_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr0_req_i = 1'b0;
  logic [4:0]  wr0_adr_i = '0;
  logic [63:0] wr0_ena_i = '0;
  logic [63:0] wr0_dat_i = '0;
  logic        wr0_ack_o;
  logic        wr1_req_i = 1'b0;
  logic [4:0]  wr1_adr_i = '0;
  logic [63:0] wr1_ena_i = '0;
  logic [63:0] wr1_dat_i = '0;
  logic        wr1_ack_o;
  logic        rd_start_i = 1'b0;
  logic [4:0]  rd_base_i = '0;
  logic [5:0]  rd_len_i = '0;
  logic        rd_busy_o;
  logic        rd_val_o;
  logic [63:0] rd_dat_o;
  logic        rd_done_o;
  logic [63:0] ram_wr_ena_o;
  logic [4:0]  ram_wr_adr_o;
  logic [63:0] ram_wr_dat_o;
  logic        ram_rd_ena_o;
  logic [4:0]  ram_rd_adr_o;
  logic [63:0] ram_rd_dat_i = '0;

  int vectors = 0;
  int errors  = 0;

  ram_tp_be_32x64_ctrl dut (
    .clk(clk), .rstn(rstn),
    .wr0_req_i(wr0_req_i), .wr0_adr_i(wr0_adr_i), .wr0_ena_i(wr0_ena_i),
    .wr0_dat_i(wr0_dat_i), .wr0_ack_o(wr0_ack_o),
    .wr1_req_i(wr1_req_i), .wr1_adr_i(wr1_adr_i), .wr1_ena_i(wr1_ena_i),
    .wr1_dat_i(wr1_dat_i), .wr1_ack_o(wr1_ack_o),
    .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
    .rd_busy_o(rd_busy_o), .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o),
    .rd_done_o(rd_done_o),
    .ram_wr_ena_o(ram_wr_ena_o), .ram_wr_adr_o(ram_wr_adr_o),
    .ram_wr_dat_o(ram_wr_dat_o),
    .ram_rd_ena_o(ram_rd_ena_o), .ram_rd_adr_o(ram_rd_adr_o),
    .ram_rd_dat_i(ram_rd_dat_i)
  );

  always #5 clk = ~clk;

  // Content of RAM row a: distinct per row so a wrong address shows in the data.
  function automatic logic [63:0] row_word(input logic [4:0] a);
    row_word = 64'h5A5A_0000_0000_0000 + ({59'd0, a} * 64'h0000_0101_0001_0011);
  endfunction

  // Minimal RAM read-port model: data valid one cycle after rd_ena.
  always @(posedge clk) begin
    if (ram_rd_ena_o) ram_rd_dat_i <= row_word(ram_rd_adr_o);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] acks;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr0_req_i  = 1'($urandom);  wr1_req_i = 1'($urandom);
      wr0_adr_i  = 5'($urandom);  wr1_adr_i = 5'($urandom);
      wr0_ena_i  = {$urandom, $urandom}; wr1_ena_i = {$urandom, $urandom};
      wr0_dat_i  = {$urandom, $urandom}; wr1_dat_i = {$urandom, $urandom};
      rd_start_i = 1'($urandom);  rd_base_i = 5'($urandom);
      rd_len_i   = 6'($urandom_range(1, 32));
      step();
      vectors++;
      if ({wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o,
           ram_rd_ena_o, ram_rd_adr_o, rd_busy_o, rd_val_o, rd_done_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: ack=%b%b wena=%h wadr=%0d wdat=%h rena=%b radr=%0d busy=%b val=%b done=%b required all 0",
                 i, wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o,
                 ram_rd_ena_o, ram_rd_adr_o, rd_busy_o, rd_val_o, rd_done_o);
      end
    end
    wr0_req_i = 0; wr1_req_i = 0; rd_start_i = 0;
    wr0_ena_i = '1; wr1_ena_i = '1;
    rstn = 1'b1;
    step();
    wr0_req_i = 1; wr0_adr_i = 5'd1;
    wr1_req_i = 1; wr1_adr_i = 5'd2;
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, ram_wr_adr_o} !== {2'b10, 5'd1}) begin
      errors++;
      $display("FAIL reset_first_grant: ack=%b%b adr=%0d required ack=10 adr=1", wr0_ack_o, wr1_ack_o, ram_wr_adr_o);
    end
    wr0_req_i = 0;
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, ram_wr_adr_o} !== {2'b01, 5'd2}) begin
      errors++;
      $display("FAIL reset_second_grant: ack=%b%b adr=%0d required ack=01 adr=2", wr0_ack_o, wr1_ack_o, ram_wr_adr_o);
    end
    wr1_req_i = 0;
    step();
    acks = {wr0_ack_o, wr1_ack_o, |ram_wr_ena_o};
    vectors++;
    if (acks !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle_after: ack/ena=%b required 000", acks);
    end
  endtask

  task automatic test_single_write();
    wr0_req_i = 1; wr0_adr_i = 5'd3; wr0_ena_i = '1; wr0_dat_i = 64'h0123_4567_89AB_CDEF;
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o} !==
        {2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL single_write: ack=%b%b ena=%h adr=%0d dat=%h required ack=10 ena=all-ones adr=3 dat=0123456789abcdef",
               wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o);
    end
    wr0_req_i = 0;
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o} !==
        {2'b00, 64'd0, 5'd3, 64'h0123_4567_89AB_CDEF}) begin
      errors++;
      $display("FAIL single_write_hold: ack=%b%b ena=%h adr=%0d dat=%h required ack=00 ena=0 adr=3 dat held",
               wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o);
    end
    // Zero-enable request is still granted and acked but writes nothing.
    wr1_req_i = 1; wr1_adr_i = 5'd17; wr1_ena_i = '0; wr1_dat_i = 64'hFEED_FACE_0BAD_F00D;
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o} !==
        {2'b01, 64'd0, 5'd17, 64'hFEED_FACE_0BAD_F00D}) begin
      errors++;
      $display("FAIL zero_ena_write: ack=%b%b ena=%h adr=%0d dat=%h required ack=01 ena=0 adr=17 dat=feedface0badf00d",
               wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ram_wr_adr_o, ram_wr_dat_o);
    end
    wr1_req_i = 0;
    step();
  endtask

  task automatic test_contention();
    logic [1:0]  eack;
    logic [4:0]  eadr;
    logic [63:0] eena;
    logic [63:0] edat;
    wr0_adr_i = 5'd5; wr0_ena_i = '1;                   wr0_dat_i = 64'hAAAA_0000_0000_0005;
    wr1_adr_i = 5'd9; wr1_ena_i = 64'h00FF_00FF_00FF_00FF; wr1_dat_i = 64'hBBBB_0000_0000_0009;
    wr0_req_i = 1; wr1_req_i = 1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i % 2 == 0) begin
        eack = 2'b10; eadr = 5'd5; eena = 64'hFFFF_FFFF_FFFF_FFFF; edat = 64'hAAAA_0000_0000_0005;
      end else begin
        eack = 2'b01; eadr = 5'd9; eena = 64'h00FF_00FF_00FF_00FF; edat = 64'hBBBB_0000_0000_0009;
      end
      vectors++;
      if ({wr0_ack_o, wr1_ack_o, ram_wr_adr_o, ram_wr_ena_o, ram_wr_dat_o} !== {eack, eadr, eena, edat}) begin
        errors++;
        $display("FAIL contention[%0d]: ack=%b%b adr=%0d ena=%h dat=%h required ack=%b adr=%0d ena=%h dat=%h",
                 i, wr0_ack_o, wr1_ack_o, ram_wr_adr_o, ram_wr_ena_o, ram_wr_dat_o, eack, eadr, eena, edat);
      end
      if (i == 7) wr1_req_i = 0;
      if (i == 8) wr0_req_i = 0;
    end
    step();
    vectors++;
    if ({wr0_ack_o, wr1_ack_o, |ram_wr_ena_o} !== 3'b000) begin
      errors++;
      $display("FAIL contention_end: ack=%b%b ena_any=%b required 000", wr0_ack_o, wr1_ack_o, |ram_wr_ena_o);
    end
  endtask

  task automatic test_persistent();
    logic ea;
    wr0_adr_i = 5'd6; wr0_ena_i = 64'h0000_0000_FFFF_0000; wr0_dat_i = 64'h6;
    wr0_req_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      ea = (i % 2 == 0);
      vectors++;
      if ({wr0_ack_o, wr1_ack_o, ram_wr_ena_o} !== {ea, 1'b0, (ea ? 64'h0000_0000_FFFF_0000 : 64'd0)}) begin
        errors++;
        $display("FAIL persistent[%0d]: ack=%b%b ena=%h required ack=%b0", i, wr0_ack_o, wr1_ack_o, ram_wr_ena_o, ea);
      end
      if (i == 4) wr0_req_i = 0;
    end
    step();
  endtask

  task automatic test_wrap_burst();
    logic [4:0] eadr;
    logic       eena, eval, edone, ebusy;
    rd_base_i = 5'd30; rd_len_i = 6'd4; rd_start_i = 1;
    step();
    rd_start_i = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      eena  = (c <= 4);
      eval  = (c >= 2 && c <= 5);
      edone = (c == 5);
      ebusy = (c <= 5);
      vectors++;
      if ({ram_rd_ena_o, rd_val_o, rd_done_o, rd_busy_o} !== {eena, eval, edone, ebusy}) begin
        errors++;
        $display("FAIL wrap_ctrl c%0d: ena/val/done/busy=%b%b%b%b required %b%b%b%b",
                 c, ram_rd_ena_o, rd_val_o, rd_done_o, rd_busy_o, eena, eval, edone, ebusy);
      end
      if (eena) begin
        eadr = 5'((30 + c - 1) % 32);
        vectors++;
        if (ram_rd_adr_o !== eadr) begin
          errors++;
          $display("FAIL wrap_adr c%0d: adr=%0d required %0d", c, ram_rd_adr_o, eadr);
        end
      end
      if (eval) begin
        eadr = 5'((30 + c - 2) % 32);
        vectors++;
        if (rd_dat_o !== row_word(eadr)) begin
          errors++;
          $display("FAIL wrap_dat c%0d: dat=%h required %h", c, rd_dat_o, row_word(eadr));
        end
      end
    end
  endtask

  task automatic test_illegal_start();
    int val_cnt, done_cnt, busy_cnt, dat_bad, done_pos;
    rd_base_i = 5'd4;
    rd_len_i = 6'd0;  rd_start_i = 1; step();
    rd_len_i = 6'd33; step();
    rd_start_i = 0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({ram_rd_ena_o, rd_busy_o, rd_val_o, rd_done_o} !== 4'b0000) begin
        errors++;
        $display("FAIL illegal_len c%0d: ena/busy/val/done=%b%b%b%b required 0000",
                 c, ram_rd_ena_o, rd_busy_o, rd_val_o, rd_done_o);
      end
      step();
    end
    val_cnt = 0; done_cnt = 0; busy_cnt = 0; dat_bad = 0; done_pos = -1;
    rd_base_i = 5'd0; rd_len_i = 6'd32; rd_start_i = 1;
    step();
    rd_start_i = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) step();
      if (c == 5) begin rd_start_i = 1; rd_base_i = 5'd10; rd_len_i = 6'd4; end
      if (c == 6) rd_start_i = 0;
      if (rd_busy_o) busy_cnt++;
      if (rd_val_o) begin
        if (rd_dat_o !== row_word(5'(val_cnt))) dat_bad++;
        val_cnt++;
      end
      if (rd_done_o) begin
        done_cnt++;
        done_pos = rd_val_o ? val_cnt : -1;
      end
    end
    vectors++;
    if ({val_cnt, done_cnt, busy_cnt, done_pos, dat_bad} !== {32'd32, 32'd1, 32'd33, 32'd32, 32'd0}) begin
      errors++;
      $display("FAIL overlap_start: val=%0d done=%0d busy=%0d done_at_val=%0d bad_dat=%0d required 32 1 33 32 0",
               val_cnt, done_cnt, busy_cnt, done_pos, dat_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic eena, ebusy, evd;
    rd_base_i = 5'd7; rd_len_i = 6'd1; rd_start_i = 1;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) step();
      eena  = (c == 1 || c == 4);
      ebusy = (c == 1 || c == 2 || c == 4 || c == 5);
      evd   = (c == 2 || c == 5);
      vectors++;
      if ({ram_rd_ena_o, rd_busy_o, rd_val_o, rd_done_o} !== {eena, ebusy, evd, evd}) begin
        errors++;
        $display("FAIL back_to_back c%0d: ena/busy/val/done=%b%b%b%b required %b%b%b%b",
                 c, ram_rd_ena_o, rd_busy_o, rd_val_o, rd_done_o, eena, ebusy, evd, evd);
      end
      if (c == 4) rd_start_i = 0;
    end
  endtask

  task automatic test_reset_mid_burst();
    int late;
    rd_base_i = 5'd0; rd_len_i = 6'd8; rd_start_i = 1;
    step();
    rd_start_i = 0;
    step();
    step();
    vectors++;
    if ({ram_rd_ena_o, ram_rd_adr_o} !== {1'b1, 5'd2}) begin
      errors++;
      $display("FAIL midburst_third_issue: ena=%b adr=%0d required 1 2", ram_rd_ena_o, ram_rd_adr_o);
    end
    rstn = 1'b0;
    step();
    vectors++;
    if ({ram_rd_ena_o, rd_val_o, rd_busy_o, rd_done_o} !== 4'b0000) begin
      errors++;
      $display("FAIL midburst_reset: ena/val/busy/done=%b%b%b%b required 0000",
               ram_rd_ena_o, rd_val_o, rd_busy_o, rd_done_o);
    end
    rstn = 1'b1;
    late = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (rd_val_o || rd_done_o || rd_busy_o) late++;
    end
    vectors++;
    if (late !== 0) begin
      errors++;
      $display("FAIL midburst_after: %0d cycles with val/done/busy required 0", late);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_persistent();
    test_wrap_burst();
    test_illegal_start();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
